// File: rtl/mcycle_issue_ctrl.sv
// rtl/mcycle_issue_ctrl.sv - mul/div issue controller: request FIFO, register scoreboard, writeback arbiter
// Optional zero-latency issue path when MCYCLE_BYPASS_EN is defined.
module mcycle_issue_ctrl #(
    parameter int width = 32,
    parameter int DEPTH = 2,
    parameter int NREG  = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ReqValid,
    input  logic             ReqOp,
    input  logic [width-1:0] ReqOp1,
    input  logic [width-1:0] ReqOp2,
    input  logic [3:0]       ReqWA3,
    output logic             ReqReady,
    input  logic [3:0]       RA1,
    input  logic [3:0]       RA2,
    input  logic             RAValid,
    output logic             Hazard,
    output logic             MStart,
    output logic             MOp,
    output logic [width-1:0] MOperand1,
    output logic [width-1:0] MOperand2,
    output logic [3:0]       MWA3,
    input  logic             MBusy,
    input  logic             MDone,
    input  logic [width-1:0] MResult,
    input  logic [3:0]       MResultWA3,
    input  logic             PipeWE,
    output logic             WBWE,
    output logic [3:0]       WBWA3,
    output logic [width-1:0] WBData
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state, state_next;

    logic             fifo_op  [DEPTH];
    logic [width-1:0] fifo_opa [DEPTH];
    logic [width-1:0] fifo_opb [DEPTH];
    logic [3:0]       fifo_wa  [DEPTH];

    logic [PW:0]   wr_ptr, rd_ptr;
    logic [PW-1:0] wr_idx, rd_idx;
    logic          full, empty;
    logic          accept, push, pop, issue, bypass, capture, wb;

    logic [NREG-1:0] pend, pend_next;

    logic             buf_valid;
    logic [3:0]       buf_wa3;
    logic [width-1:0] buf_data;

    logic             op_q;
    logic [width-1:0] opa_q, opb_q;
    logic [3:0]       wa_q;

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

    // WAW guard uses registered pend only, so a register clearing this cycle is accepted next cycle
    assign ReqReady = !full && !pend[ReqWA3];
    assign accept   = ReqValid && ReqReady;
    assign Hazard   = RAValid && (pend[RA1] || pend[RA2]);

    assign issue = (state == IDLE) && !empty && !MBusy && !buf_valid;
`ifdef MCYCLE_BYPASS_EN
    assign bypass = accept && empty && (state == IDLE) && !MBusy && !buf_valid;
`else
    assign bypass = 1'b0;
`endif
    assign push = accept && !bypass;

    assign wb     = buf_valid && !PipeWE;
    assign WBWE   = wb;
    assign WBWA3  = buf_wa3;
    assign WBData = buf_data;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue || bypass) state_next = RUN;
            RUN:     if (MDone) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        MStart    = 1'b0;
        pop       = 1'b0;
        capture   = 1'b0;
        MOp       = op_q;
        MOperand1 = opa_q;
        MOperand2 = opb_q;
        MWA3      = wa_q;
        case (state)
            IDLE: begin
                if (issue) begin
                    MStart    = 1'b1;
                    pop       = 1'b1;
                    MOp       = fifo_op[rd_idx];
                    MOperand1 = fifo_opa[rd_idx];
                    MOperand2 = fifo_opb[rd_idx];
                    MWA3      = fifo_wa[rd_idx];
                end
`ifdef MCYCLE_BYPASS_EN
                else if (bypass) begin
                    MStart    = 1'b1;
                    MOp       = ReqOp;
                    MOperand1 = ReqOp1;
                    MOperand2 = ReqOp2;
                    MWA3      = ReqWA3;
                end
`endif
            end
            RUN:     capture = MDone;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_op[wr_idx]  <= ReqOp;
            fifo_opa[wr_idx] <= ReqOp1;
            fifo_opb[wr_idx] <= ReqOp2;
            fifo_wa[wr_idx]  <= ReqWA3;
        end
    end

    // Operands stay on the unit interface after the start pulse
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            op_q  <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            wa_q  <= '0;
        end else if (MStart) begin
            op_q  <= MOp;
            opa_q <= MOperand1;
            opb_q <= MOperand2;
            wa_q  <= MWA3;
        end
    end

    always_comb begin
        pend_next = pend;
        if (wb)     pend_next[buf_wa3] = 1'b0;
        if (accept) pend_next[ReqWA3]  = 1'b1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) pend <= '0;
        else       pend <= pend_next;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            buf_valid <= 1'b0;
            buf_wa3   <= '0;
            buf_data  <= '0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_wa3   <= MResultWA3;
            buf_data  <= MResult;
        end else if (wb) begin
            buf_valid <= 1'b0;
        end
    end
endmodule

// File: doc/mcycle_issue_ctrl.md
Name: mcycle_issue_ctrl

Overview:
- Issue controller between decode and the multi-cycle multiply/divide unit.
- Queues mul/div requests in a small FIFO and issues them one at a time (Start pulse) when the unit is idle.
- Tracks destination registers in a scoreboard so that dependent reads stall.
- Arbitrates the unit's result onto the shared register-file write port, yielding to the main pipeline.

Parameters:
- width, 32, operand/result width
- DEPTH, 2, request FIFO entries (power of 2, >=2)
- NREG, 16, architectural registers (scoreboard bits; address width 4)

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  decode offers a mul/div
- ReqOp  in  1  0=multiply, 1=divide
- ReqOp1  in  width  multiplicand/dividend
- ReqOp2  in  width  multiplier/divisor
- ReqWA3  in  4  destination register
- ReqReady  out  1  request accepted this cycle when ReqValid&ReqReady
- RA1, RA2  in  4 each  decode source registers
- RAValid  in  1  decode sources are live
- Hazard  out  1  RAValid & (pend[RA1] | pend[RA2])
- MStart  out  1  one-cycle start pulse to the unit
- MOp  out  1  op for the unit
- MOperand1, MOperand2  out  width  operands for the unit
- MWA3  out  4  destination for the unit
- MBusy  in  1  unit busy
- MDone  in  1  unit done pulse; MResult/MResultWA3 valid this cycle
- MResult  in  width  result
- MResultWA3  in  4  result destination
- PipeWE  in  1  main pipeline owns the write port this cycle
- WBWE  out  1  write result this cycle
- WBWA3  out  4  write destination
- WBData  out  width  write data

Behaviour:
- Reset values: FIFO empty, pointers 0, scoreboard all 0, FSM IDLE, result buffer empty. MStart=0, WBWE=0, WBWA3=0, WBData=0, MOp=0, MOperand1/2=0, MWA3=0. Hazard=0.
- Reset mid-operation discards queued and in-flight ops without any writeback. The unit shares Reset.
- ReqReady = !full & !pend[ReqWA3]. The WAW check uses registered pend only.
- A request whose register is being cleared this cycle is not accepted; it is accepted next cycle.
- On accept: push {ReqOp, ReqOp1, ReqOp2, ReqWA3} and set pend[ReqWA3] at the clock edge.
- FIFO: circular, wrap at DEPTH. full/empty use an extra pointer bit. Push and pop in the same cycle is legal, including when full (pop frees a slot first only if ReqReady already permitted).
- FSM IDLE:
  - If !empty & !MBusy & result buffer empty, register MStart=1 with head entry fields on MOp/MOperand*/MWA3.
  - Pop the head and go to RUN.
  - Accept-to-MStart latency is 1 cycle minimum.
- FSM RUN:
  - MStart=0.
  - On MDone, capture MResult/MResultWA3 into the result buffer and go to IDLE.
  - MOperand*/MWA3 hold their last values.
- Writeback:
  - Buffer full & !PipeWE gives WBWE=1 with WBWA3/WBData from the buffer, registered. The earliest cycle is MDone+1.
  - In that WB cycle, the buffer empties and pend[WBWA3] clears at the edge.
  - PipeWE=1 holds the buffer indefinitely.
  - No new issue while the buffer is full.
- Scoreboard set and clear of different registers in the same cycle both take effect. Set and clear of the same register cannot coincide (guaranteed by ReqReady).
- Hazard is combinational from registered pend. Pending is cleared on the WB edge; there is no forwarding.

Optional Feature:
- MCYCLE_BYPASS_EN, when defined:
  - If FIFO empty, FSM IDLE, !MBusy, buffer empty and the request is accepted, drive MStart combinationally in the accept cycle with the Req* fields (muxed onto MOp/MOperand*/MWA3). Latency is 0.
  - Nothing is pushed.
  - pend is still set at the edge.
- When undefined: all requests pass through the FIFO, with latency 1.

Test Plan:
- Reset, then accept mul (ReqOp=0, 7, 6, WA3=2); MDone with MResult=42 while PipeWE=0 -> MStart 1 cycle after accept; WBWE=1, WBWA3=2, WBData=42 at MDone+1; pend[2] clears; Hazard for RA1=2 drops after WB.
- Three back-to-back requests (WA3=1,3,4) with DEPTH=2 while the unit is busy -> ReqReady drops when full; issued strictly in order; each MStart only after the previous WB buffer empties.
- Request to WA3=5 while pend[5]=1 -> ReqReady=0 until the WB cycle for 5; accepted the cycle after.
- MDone (div, result 3, WA3=6) while PipeWE=1 for 4 cycles -> WBWE=0 throughout; no MStart for queued ops; WBWE=1 on the first cycle PipeWE=0.
- Assert Reset during RUN with 2 queued -> all outputs return to reset values; no WBWE after release; scoreboard 0 (Hazard=0 for any RA).
- With MCYCLE_BYPASS_EN, an idle accept -> MStart in the same cycle as the accept with the Req* operands; the same stimulus without the macro -> MStart one cycle later.
